// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: IO-mapped multiplexed 7-segment controller with PWM dimming; define SEG_LZ_SUPPRESS_EN for leading-zero suppression
module seg_display_ctrl #(
  parameter int          NUM_DIGITS  = 8,
  parameter int          REFRESH_DIV = 5000,
  parameter logic [11:0] BASE_ADDR   = 12'h000,
  parameter int          PWM_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IOen,
  input  logic [11:0]           IOaddr,
  input  logic [31:0]           IOwdata,
  output logic [NUM_DIGITS-1:0] led_en,
  output logic [6:0]            seg,
  output logic                  led_dp
);
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] DEC [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                      7'h00, 7'h0C, 7'h08, 7'h60, 7'h72, 7'h42, 7'h30, 7'h38};
  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, en_q, en_d, led_en_q, led_en_d, lz;
  logic [PWM_BITS-1:0]     bright_q, bright_d, pwm_q, pwm_d;
  logic [SW-1:0]           slot_q, slot_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic                    led_dp_q, led_dp_d, slot_wrap, on;
`ifdef SEG_LZ_SUPPRESS_EN
  // digit i is blank when it and every digit to its left hold zero
  always_comb
    for (int i = 0; i < NUM_DIGITS; i++) lz[i] = (i > 0) && ((data_q >> (4 * i)) == '0);
`else
  assign lz = '0;
`endif
  always_comb begin
    data_d    = (IOen && IOaddr == BASE_ADDR)          ? IOwdata[4*NUM_DIGITS-1:0] : data_q;
    dp_d      = (IOen && IOaddr == BASE_ADDR + 12'h4)  ? IOwdata[NUM_DIGITS-1:0]   : dp_q;
    en_d      = (IOen && IOaddr == BASE_ADDR + 12'h8)  ? IOwdata[NUM_DIGITS-1:0]   : en_q;
    bright_d  = (IOen && IOaddr == BASE_ADDR + 12'hC)  ? IOwdata[PWM_BITS-1:0]     : bright_q;
    slot_wrap = slot_q == SW'(REFRESH_DIV - 1);
    slot_d    = slot_wrap ? '0 : slot_q + SW'(1);
    idx_d     = !slot_wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    pwm_d     = pwm_q + PWM_BITS'(1);
    on        = en_q[idx_q] && (pwm_q <= bright_q) && !lz[idx_q];
    led_en_d  = on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d     = on ? DEC[data_q[4*idx_q +: 4]] : 7'h7F;
    led_dp_d  = on ? ~dp_q[idx_q] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q   <= '0;
      dp_q     <= '0;
      en_q     <= '1;
      bright_q <= '1;
      slot_q   <= '0;
      idx_q    <= '0;
      pwm_q    <= '0;
      led_en_q <= '1;
      seg_q    <= 7'h7F;
      led_dp_q <= 1'b1;
    end else begin
      data_q   <= data_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      bright_q <= bright_d;
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      pwm_q    <= pwm_d;
      led_en_q <= led_en_d;
      seg_q    <= seg_d;
      led_dp_q <= led_dp_d;
    end
  assign led_en = led_en_q;
  assign seg    = seg_q;
  assign led_dp = led_dp_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: randomized bench for seg_display_ctrl against a cycle-count based display model
module tb_seg_display_ctrl;
  localparam int ND = 8, RD = 20, PB = 4;
  localparam logic [11:0] BA = 12'h100;
  logic clk = 0, rst_n = 1, IOen = 0;
  logic [11:0] IOaddr = 0;
  logic [31:0] IOwdata = 0;
  logic [ND-1:0] led_en;
  logic [6:0] seg;
  logic led_dp;
  int n_cmp = 0, n_err = 0;

  seg_display_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BASE_ADDR(BA), .PWM_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .IOen(IOen), .IOaddr(IOaddr), .IOwdata(IOwdata),
    .led_en(led_en), .seg(seg), .led_dp(led_dp));

  always #5 clk = ~clk;

  // model: display state is a pure function of edges since reset (k) and the register file
  logic [6:0] hex [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                           7'h00, 7'h0C, 7'h08, 7'h60, 7'h72, 7'h42, 7'h30, 7'h38};
  logic [4*ND-1:0] m_data;
  logic [ND-1:0] m_dp, m_en, e_led;
  logic [PB-1:0] m_br;
  logic [6:0] e_seg;
  logic e_dp;
  int k;

  function automatic bit blank_lz(int d);
`ifdef SEG_LZ_SUPPRESS_EN
    return d > 0 && (m_data >> (4 * d)) == 0;
`else
    return d < 0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int d;
    bit on;
    if (!rst_n) begin
      m_data = 0; m_dp = 0; m_en = '1; m_br = '1; k = 0;
      e_led = '1; e_seg = 7'h7F; e_dp = 1;
    end else begin
      d = (k / RD) % ND;
      on = m_en[d] && (k % (1 << PB)) <= int'(m_br) && !blank_lz(d);
      e_led = on ? ~(ND'(1) << d) : '1;
      e_seg = on ? hex[m_data[4*d +: 4]] : 7'h7F;
      e_dp = on ? ~m_dp[d] : 1'b1;
      if (IOen) begin
        if (IOaddr == BA)          m_data = IOwdata[4*ND-1:0];
        if (IOaddr == BA + 12'h4)  m_dp = IOwdata[ND-1:0];
        if (IOaddr == BA + 12'h8)  m_en = IOwdata[ND-1:0];
        if (IOaddr == BA + 12'hC)  m_br = IOwdata[PB-1:0];
      end
      k++;
    end
  end

  task automatic io_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    IOen = 1; IOaddr = a; IOwdata = d;
    @(negedge clk);
    IOen = 0;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    n_cmp++;
    if ({led_en, seg, led_dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_err++; $display("FAIL reset_vals: got %h/%h/%b want ff/7f/1", led_en, seg, led_dp);
    end
    @(negedge clk) rst_n = 1;
    for (int i = 0; i <= RD; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({led_en, seg} !== {(i < RD) ? 8'hFE : 8'hFD, 7'h01}) begin
        n_err++; $display("FAIL reset_scan c%0d: got %h/%h want %h/01", i, led_en, seg, (i < RD) ? 8'hFE : 8'hFD);
      end
    end
  endtask

  task automatic test_scan();
    repeat (ND * RD + 7) begin
      @(negedge clk);
      n_cmp++;
      if ({led_en, seg, led_dp} !== {e_led, e_seg, e_dp}) begin
        n_err++; $display("FAIL scan k%0d: got %h/%h/%b want %h/%h/%b", k, led_en, seg, led_dp, e_led, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_data();
    @(negedge clk);
    IOen = 1; IOaddr = BA; IOwdata = 32'h89ABCDEF;
    repeat (ND * RD + 3) begin
      @(negedge clk);
      IOen = 0;
      n_cmp++;
      if ({led_en, seg, led_dp} !== {e_led, e_seg, e_dp}) begin
        n_err++; $display("FAIL data k%0d: got %h/%h/%b want %h/%h/%b", k, led_en, seg, led_dp, e_led, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_dp_en();
    int blank = 0;
    io_write(BA + 12'h4, 32'h05);
    io_write(BA + 12'h8, 32'hFB);
    repeat (ND * RD) begin
      @(negedge clk);
      if (led_en === 8'hFF) blank++;
      n_cmp++;
      if ({led_en, seg, led_dp} !== {e_led, e_seg, e_dp}) begin
        n_err++; $display("FAIL dp_en k%0d: got %h/%h/%b want %h/%h/%b", k, led_en, seg, led_dp, e_led, e_seg, e_dp);
      end
    end
    n_cmp++;
    if (blank != RD) begin
      n_err++; $display("FAIL dp_en_blank: got %0d blank cycles want %0d", blank, RD);
    end
  endtask

  task automatic test_bright();
    int lit;
    io_write(BA + 12'h8, 32'hFF);
    for (int b = 0; b < 2; b++) begin
      io_write(BA + 12'hC, b ? 32'h0 : 32'h3);
      lit = 0;
      repeat (ND * RD) begin
        @(negedge clk);
        if (led_en !== 8'hFF) lit++;
        n_cmp++;
        if ({led_en, seg, led_dp} !== {e_led, e_seg, e_dp}) begin
          n_err++; $display("FAIL bright k%0d: got %h/%h/%b want %h/%h/%b", k, led_en, seg, led_dp, e_led, e_seg, e_dp);
        end
      end
      n_cmp++;
      if (lit != (b ? 1 : 4) * ND * RD / 16) begin
        n_err++; $display("FAIL bright_duty b%0d: got %0d lit want %0d", b, lit, (b ? 1 : 4) * ND * RD / 16);
      end
    end
    io_write(BA + 12'hC, 32'hF);
  endtask

  task automatic test_lz();
`ifdef SEG_LZ_SUPPRESS_EN
    int lit;
    io_write(BA + 12'h4, 32'h0);
    for (int p = 0; p < 2; p++) begin
      io_write(BA, p ? 32'h0 : 32'h120);
      lit = 0;
      repeat (ND * RD) begin
        @(negedge clk);
        if (led_en !== 8'hFF) lit++;
        n_cmp++;
        if ({led_en, seg, led_dp} !== {e_led, e_seg, e_dp}) begin
          n_err++; $display("FAIL lz k%0d: got %h/%h/%b want %h/%h/%b", k, led_en, seg, led_dp, e_led, e_seg, e_dp);
        end
      end
      n_cmp++;
      if (lit != (p ? 1 : 3) * RD) begin
        n_err++; $display("FAIL lz_count p%0d: got %0d want %0d", p, lit, (p ? 1 : 3) * RD);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [11:0] addrs [5];
    addrs = '{BA, BA + 12'h4, BA + 12'h8, BA + 12'hC, 12'h0};
    repeat (1500) begin
      @(negedge clk);
      n_cmp++;
      if ({led_en, seg, led_dp} !== {e_led, e_seg, e_dp}) begin
        n_err++; $display("FAIL random k%0d: got %h/%h/%b want %h/%h/%b", k, led_en, seg, led_dp, e_led, e_seg, e_dp);
      end
      IOen = ($urandom_range(0, 9) < 3);
      IOaddr = addrs[$urandom_range(0, 4)];
      if (IOaddr == 12'h0) IOaddr = 12'($urandom_range(0, 4095));
      IOwdata = $urandom;
    end
    IOen = 0;
  endtask

  task automatic test_mid_reset();
    int budget = 4 * ND * RD;
    io_write(BA, 32'h89ABCDEF);
    while (!(((k / RD) % ND) == 5 && (k % RD) == RD / 2) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_err++; $display("FAIL mid_reset_wait: slot 5 not reached, k=%0d", k);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({led_en, seg, led_dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_err++; $display("FAIL mid_reset_vals: got %h/%h/%b want ff/7f/1", led_en, seg, led_dp);
    end
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if ({led_en, seg, led_dp} !== {8'hFE, 7'h01, 1'b1}) begin
      n_err++; $display("FAIL mid_reset_restart: got %h/%h/%b want fe/01/1", led_en, seg, led_dp);
    end
    repeat (ND * RD + 3) begin
      @(negedge clk);
      n_cmp++;
      if ({led_en, seg, led_dp} !== {e_led, e_seg, e_dp}) begin
        n_err++; $display("FAIL mid_reset k%0d: got %h/%h/%b want %h/%h/%b", k, led_en, seg, led_dp, e_led, e_seg, e_dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_data();
    test_dp_en();
    test_bright();
    test_lz();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
